div_arbiter: RTL and testbench

- Round-robin scheduler that shares one iterative divider (start/numerador/denominador -> cociente/resto/done) among NREQ requesters.
- Latches the winning requester's operands and pulses the divider's start.
- Waits for done, or aborts on timeout, then routes the result back to the winner.
- Sits between the requesting datapath blocks and the single divider instance.

---
 rtl/div_arb_pkg.sv | 44 ++++
 rtl/div_arbiter_rr_arbiter.sv | 48 ++++
 rtl/div_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_div_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// Shared types and helpers for the divider arbiter: FSM state encoding and round-robin pick.
// SIZE is limited to MAX_SIZE and NREQ to MAX_NREQ by the widths used here.
package div_arb_pkg;

    localparam int MAX_SIZE = 64;
    localparam int MAX_NREQ = 16;
    localparam logic [MAX_SIZE-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // Scan from ptr upward and wrap at nreq; the first set request wins.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                      input logic [3:0]          ptr,
                                      input int                  nreq);
        pick_t pick;
        int    pos;
        pick = '0;
        pos  = 0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            if (k < nreq && !pick.found) begin
                pos = int'(ptr) + k;
                if (pos >= nreq) begin
                    pos = pos - nreq;
                end
                if (req[pos]) begin
                    pick.found = 1'b1;
                    pick.idx   = 4'(pos);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational winner selection plus the registered rotation pointer.
// The pointer moves to one past the index presented on adv_idx whenever advance is high.
module rr_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic                     advance,
    input  logic [$clog2(NREQ)-1:0]  adv_idx,
    output logic                     pick_found,
    output logic [$clog2(NREQ)-1:0]  pick_idx
);

    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    pick_t            pick;

    always_comb begin
        pick       = rr_pick(MAX_NREQ'(req), 4'(ptr_q), NREQ);
        pick_found = pick.found;
        pick_idx   = IDX_W'(pick.idx);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            if (adv_idx == IDX_W'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = adv_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider among NREQ requesters with round-robin grant and a done timeout.
// Optional macro DIV_ZERO_BYPASS_EN answers zero-denominator requests without using the divider.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int SIZE    = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ack,
    input  logic [NREQ*SIZE-1:0] req_numerador,
    input  logic [NREQ*SIZE-1:0] req_denominador,
    output logic [NREQ-1:0]      resp_done,
    output logic [SIZE-1:0]      resp_cociente,
    output logic [SIZE-1:0]      resp_resto,
    output logic                 resp_err,
    output logic                 div_start,
    output logic [SIZE-1:0]      div_numerador,
    output logic [SIZE-1:0]      div_denominador,
    input  logic [SIZE-1:0]      div_cociente,
    input  logic [SIZE-1:0]      div_resto,
    input  logic                 div_done,
    output logic                 busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state_q,     state_d;
    logic [IDX_W-1:0]  grant_q,     grant_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [NREQ-1:0]   req_ack_q,   req_ack_d;
    logic              div_start_q, div_start_d;
    logic [SIZE-1:0]   div_num_q,   div_num_d;
    logic [SIZE-1:0]   div_den_q,   div_den_d;
    logic [NREQ-1:0]   resp_done_q, resp_done_d;
    logic [SIZE-1:0]   resp_coc_q,  resp_coc_d;
    logic [SIZE-1:0]   resp_rem_q,  resp_rem_d;
    logic              resp_err_q,  resp_err_d;
    logic              busy_q,      busy_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [NREQ-1:0]   pick_onehot;
    logic [NREQ-1:0]   grant_onehot;
    logic [SIZE-1:0]   winner_num;
    logic [SIZE-1:0]   winner_den;
    logic              bypass_take;
    logic              rr_advance;
    logic [IDX_W-1:0]  rr_adv_idx;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .clk        (clk),
        .rst        (rst),
        .req        (req_valid),
        .advance    (rr_advance),
        .adv_idx    (rr_adv_idx),
        .pick_found (pick_found),
        .pick_idx   (pick_idx)
    );

    assign pick_onehot  = NREQ'(1) << pick_idx;
    assign grant_onehot = NREQ'(1) << grant_q;
    assign winner_num   = req_numerador[int'(pick_idx) * SIZE +: SIZE];
    assign winner_den   = req_denominador[int'(pick_idx) * SIZE +: SIZE];

`ifdef DIV_ZERO_BYPASS_EN
    assign bypass_take = (state_q == IDLE) && pick_found && (winner_den == '0);
`else
    assign bypass_take = 1'b0;
`endif

    // A bypassed request never passes through ISSUE, so the pointer moves on the IDLE win instead.
    assign rr_advance = (state_q == ISSUE) || bypass_take;
    assign rr_adv_idx = bypass_take ? pick_idx : grant_q;

    // Every output is registered; the _d values describe what is driven in the following cycle.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        req_ack_d   = '0;
        div_start_d = 1'b0;
        div_num_d   = div_num_q;
        div_den_d   = div_den_q;
        resp_done_d = '0;
        resp_coc_d  = '0;
        resp_rem_d  = '0;
        resp_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    if (bypass_take) begin
                        state_d     = RESP;
                        req_ack_d   = pick_onehot;
                        resp_done_d = pick_onehot;
                        resp_coc_d  = ALL_ONES[SIZE-1:0];
                        resp_rem_d  = winner_num;
                    end else begin
                        state_d     = ISSUE;
                        div_num_d   = winner_num;
                        div_den_d   = winner_den;
                        req_ack_d   = pick_onehot;
                        div_start_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (div_done) begin
                    state_d     = RESP;
                    resp_done_d = grant_onehot;
                    resp_coc_d  = div_cociente;
                    resp_rem_d  = div_resto;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    resp_done_d = grant_onehot;
                    resp_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            cnt_q       <= '0;
            req_ack_q   <= '0;
            div_start_q <= 1'b0;
            div_num_q   <= '0;
            div_den_q   <= '0;
            resp_done_q <= '0;
            resp_coc_q  <= '0;
            resp_rem_q  <= '0;
            resp_err_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            req_ack_q   <= req_ack_d;
            div_start_q <= div_start_d;
            div_num_q   <= div_num_d;
            div_den_q   <= div_den_d;
            resp_done_q <= resp_done_d;
            resp_coc_q  <= resp_coc_d;
            resp_rem_q  <= resp_rem_d;
            resp_err_q  <= resp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ack         = req_ack_q;
    assign div_start       = div_start_q;
    assign div_numerador   = div_num_q;
    assign div_denominador = div_den_q;
    assign resp_done       = resp_done_q;
    assign resp_cociente   = resp_coc_q;
    assign resp_resto      = resp_rem_q;
    assign resp_err        = resp_err_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: a latency-programmable divider model plus a result scoreboard.
// Zero-denominator expectations follow DIV_ZERO_BYPASS_EN when the bench is built with it.
module tb_div_arbiter;

    localparam int SIZE    = 32;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 255;

    typedef struct {
        int              idx;
        logic [SIZE-1:0] coc;
        logic [SIZE-1:0] rem;
        logic            err;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ack;
    logic [NREQ*SIZE-1:0] req_numerador = '0;
    logic [NREQ*SIZE-1:0] req_denominador = '0;
    logic [NREQ-1:0]      resp_done;
    logic [SIZE-1:0]      resp_cociente;
    logic [SIZE-1:0]      resp_resto;
    logic                 resp_err;
    logic                 div_start;
    logic [SIZE-1:0]      div_numerador;
    logic [SIZE-1:0]      div_denominador;
    logic [SIZE-1:0]      div_cociente = '0;
    logic [SIZE-1:0]      div_resto = '0;
    logic                 div_done = 1'b0;
    logic                 busy;

    int              div_lat = 10;
    bit              div_never = 1'b0;
    int              m_cnt = 0;
    logic [SIZE-1:0] m_num = '0;
    logic [SIZE-1:0] m_den = '0;

    int              vectors = 0;
    int              miscompares = 0;
    int              cycle = 0;
    int              ack_cycle = 0;
    int              start_cycle = 0;
    int              resp_cycle = 0;
    int              ack_count = 0;
    int              start_count = 0;
    int              resp_count = 0;
    logic [SIZE-1:0] start_den = '0;
    bit              idle_bus_bad = 1'b0;
    int              ack_log[$];
    int              rounds_left[NREQ] = '{default: 0};
    int              rr_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_t            sb[$];

    div_arbiter #(
        .SIZE    (SIZE),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ack         (req_ack),
        .req_numerador   (req_numerador),
        .req_denominador (req_denominador),
        .resp_done       (resp_done),
        .resp_cociente   (resp_cociente),
        .resp_resto      (resp_resto),
        .resp_err        (resp_err),
        .div_start       (div_start),
        .div_numerador   (div_numerador),
        .div_denominador (div_denominador),
        .div_cociente    (div_cociente),
        .div_resto       (div_resto),
        .div_done        (div_done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Divider stand-in: done pulses div_lat+1 cycles after start; it deliberately ignores rst.
    always @(posedge clk) begin
        if (div_start) begin
            m_cnt <= div_never ? 0 : div_lat;
            m_num <= div_numerador;
            m_den <= div_denominador;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end
        div_done <= !div_start && (m_cnt == 1);
        if (!div_start && m_cnt == 1) begin
            div_cociente <= (m_den == '0) ? '1 : m_num / m_den;
            div_resto    <= (m_den == '0) ? m_num : m_num % m_den;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [SIZE-1:0] num, input logic [SIZE-1:0] den,
                                 input bit timeout_expected, input bit resp_expected);
        exp_t e;
        req_numerador[idx*SIZE +: SIZE]   = num;
        req_denominador[idx*SIZE +: SIZE] = den;
        req_valid[idx] = 1'b1;
        if (resp_expected) begin
            e.idx = idx;
            if (timeout_expected) begin
                e.coc = '0;
                e.rem = '0;
                e.err = 1'b1;
            end else if (den == '0) begin
                e.coc = '1;
                e.rem = num;
                e.err = 1'b0;
            end else begin
                e.coc = num / den;
                e.rem = num % den;
                e.err = 1'b0;
            end
            sb.push_back(e);
        end
    endtask

    // One clock: sample at the falling edge, retire acked requests and score any response.
    task automatic step();
        int widx;
        int hit;
        @(negedge clk);
        cycle++;
        if (req_ack != '0) begin
            checkOutput("ack_onehot", $countones(req_ack), 1);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ack[i]) begin
                    ack_log.push_back(i);
                    ack_count++;
                    ack_cycle = cycle;
                    if (rounds_left[i] > 0) begin
                        rounds_left[i]--;
                        applyStimulus(i, $urandom, $urandom_range(1, 5000), 1'b0, 1'b1);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
        end
        if (div_start) begin
            start_count++;
            start_cycle = cycle;
            start_den   = div_denominador;
        end
        if (resp_done != '0) begin
            resp_count++;
            resp_cycle = cycle;
            checkOutput("resp_onehot", $countones(resp_done), 1);
            widx = -1;
            for (int i = 0; i < NREQ; i++) begin
                if (resp_done[i] && widx < 0) widx = i;
            end
            hit = -1;
            for (int j = 0; j < sb.size(); j++) begin
                if (hit < 0 && sb[j].idx == widx) hit = j;
            end
            if (hit < 0) begin
                checkOutput("resp_unexpected", resp_done, 0);
            end else begin
                checkOutput("resp_cociente", resp_cociente, sb[hit].coc);
                checkOutput("resp_resto", resp_resto, sb[hit].rem);
                checkOutput("resp_err", resp_err, sb[hit].err);
                sb.delete(hit);
            end
        end else if (resp_cociente != '0 || resp_resto != '0 || resp_err != 1'b0) begin
            idle_bus_bad = 1'b1;
        end
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int k;
        k = 0;
        while (k < budget && !(busy == 1'b0 && req_valid == '0 && sb.size() == 0)) begin
            step();
            k++;
        end
        checkOutput(tag, (busy == 1'b0 && req_valid == '0 && sb.size() == 0), 1);
    endtask

    initial begin
        int a0;
        int s0;
        int r0;

        step();
        step();
        checkOutput("reset_ctrl", {busy, req_ack, div_start, resp_done, resp_err}, 0);
        checkOutput("reset_resp_buses", {resp_cociente, resp_resto}, 0);
        checkOutput("reset_div_ops", {div_numerador, div_denominador}, 0);
        rst = 1'b0;

        // Single requester 2 with 100/7 through a 10-cycle divider.
        div_lat = 10;
        a0 = ack_count;
        s0 = start_count;
        ack_log.delete();
        applyStimulus(2, 32'd100, 32'd7, 1'b0, 1'b1);
        waitIdle("t1_idle", 100);
        checkOutput("t1_ack_count", ack_count - a0, 1);
        checkOutput("t1_start_count", start_count - s0, 1);
        checkOutput("t1_grant", (ack_log.size() > 0) ? ack_log[0] : -1, 2);
        checkOutput("t1_latency", resp_cycle - ack_cycle, 12);
        checkOutput("t1_operand", start_den, 7);

        // Reset while waiting; the later divider done must not produce a response.
        div_lat = 50;
        r0 = resp_count;
        applyStimulus(2, 32'd900, 32'd9, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 70; k++) step();
        checkOutput("rst_no_resp", resp_count - r0, 0);
        checkOutput("rst_busy", busy, 0);

        div_lat = 5;
        ack_log.delete();
        applyStimulus(3, 32'd77, 32'd5, 1'b0, 1'b1);
        applyStimulus(1, 32'd1234, 32'd11, 1'b0, 1'b1);
        waitIdle("rst_followup_idle", 200);
        checkOutput("rst_first_grant", (ack_log.size() > 0) ? ack_log[0] : -1, 1);
        checkOutput("rst_second_grant", (ack_log.size() > 1) ? ack_log[1] : -1, 3);

        // All four requesters keep requesting; grants must rotate 0,1,2,3,0,1,2,3.
        div_lat = 3;
        ack_log.delete();
        rounds_left = '{1, 1, 1, 1};
        for (int i = 0; i < NREQ; i++) begin
            applyStimulus(i, $urandom, $urandom_range(1, 5000), 1'b0, 1'b1);
        end
        waitIdle("rr_idle", 600);
        for (int k = 0; k < 8; k++) begin
            checkOutput("rr_order", (k < ack_log.size()) ? ack_log[k] : -1, rr_order[k]);
        end

        // Divider never answers: error response TIMEOUT+1 cycles after start.
        div_never = 1'b1;
        applyStimulus(1, 32'd500, 32'd5, 1'b1, 1'b1);
        waitIdle("tmo_idle", 400);
        checkOutput("tmo_latency", resp_cycle - start_cycle, TIMEOUT + 1);
        checkOutput("tmo_busy", busy, 0);
        div_never = 1'b0;

        // Done lands in the same cycle as the timeout; the result wins.
        div_lat = TIMEOUT - 1;
        applyStimulus(0, 32'd1000, 32'd10, 1'b0, 1'b1);
        waitIdle("coincide_idle", 400);
        checkOutput("coincide_latency", resp_cycle - start_cycle, TIMEOUT + 1);

        // Zero denominator from requester 1.
        div_lat = 4;
        s0 = start_count;
        applyStimulus(1, 32'd55, 32'd0, 1'b0, 1'b1);
        waitIdle("zero_idle", 100);
`ifdef DIV_ZERO_BYPASS_EN
        checkOutput("zero_no_start", start_count - s0, 0);
        checkOutput("zero_ack_with_resp", resp_cycle - ack_cycle, 0);
`else
        checkOutput("zero_start", start_count - s0, 1);
        checkOutput("zero_den_forwarded", start_den, 0);
`endif

        checkOutput("idle_resp_bus", idle_bus_bad, 0);
        checkOutput("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
